// File: rtl/pow_25519.sv
// Modular exponentiation a^e mod 2^255-19 (inverse, sqrt-candidate or user exponent) on a shared radix-2^32 multiplier.
// Optional macro POW_CT_EN: constant-time square-and-always-multiply over all EXP_W exponent bits.
module mul_25519 (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [254:0] x,
   input  logic [254:0] y,
   output logic         busy,
   output logic         done,
   output logic [254:0] res
);
   localparam logic [254:0] P = {255{1'b1}} - 255'd18;

   logic         busy_q, busy_d, done_q, done_d;
   logic [2:0]   cnt_q, cnt_d;
   logic [254:0] acc_q, acc_d, x_q, x_d;
   logic [255:0] y_q, y_d;
   logic [287:0] t;
   logic [255:0] t1, t2;

   // Horner step: acc*2^32 + digit*x, folded with 2^255 = 19 (mod p); one subtract suffices.
   always_comb begin
      t  = {1'b0, acc_q, 32'd0} + 288'(y_q[255:224]) * 288'(x_q);
      t1 = 256'(t[254:0]) + 256'(t[287:255]) * 256'd19;
      t2 = (t1 >= 256'(P)) ? t1 - 256'(P) : t1;
   end

   always_comb begin
      busy_d = busy_q;
      done_d = 1'b0;
      cnt_d  = cnt_q;
      acc_d  = acc_q;
      x_d    = x_q;
      y_d    = y_q;
      if (busy_q) begin
         acc_d = t2[254:0];
         y_d   = {y_q[223:0], 32'd0};
         cnt_d = cnt_q - 3'd1;
         if (cnt_q == 3'd0) begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end
      end else if (start) begin
         busy_d = 1'b1;
         cnt_d  = 3'd7;
         acc_d  = '0;
         x_d    = x;
         y_d    = {1'b0, y};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_q <= 1'b0;
         done_q <= 1'b0;
         cnt_q  <= '0;
         acc_q  <= '0;
         x_q    <= '0;
         y_q    <= '0;
      end else begin
         busy_q <= busy_d;
         done_q <= done_d;
         cnt_q  <= cnt_d;
         acc_q  <= acc_d;
         x_q    <= x_d;
         y_q    <= y_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign res  = acc_q;
endmodule

module pow_25519 #(
   parameter int EXP_W = 255,
   parameter int IDX_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic [254:0]     a,
   input  logic [EXP_W-1:0] e,
   output logic [254:0]     res,
   output logic             done,
   output logic             err,
   output logic             busy
);
   localparam logic [254:0] P       = {255{1'b1}} - 255'd18;
   localparam logic [254:0] E_INV   = P - 255'd2;
   localparam logic [254:0] E_SQRT  = (255'd1 << 252) - 255'd3;
   localparam logic [EXP_W-1:0] E_INV_W  = E_INV[EXP_W-1:0];
   localparam logic [EXP_W-1:0] E_SQRT_W = E_SQRT[EXP_W-1:0];
   localparam logic [254:0] ONE     = 255'd1;

   typedef enum logic [2:0] {IDLE, SCAN, SQR, MUL, FINISH} state_t;

   state_t             state_q, state_d;
   logic [254:0]       base_q, base_d, result_q, result_d, res_q, res_d;
   logic [EXP_W-1:0]   exp_q, exp_d;
   logic [1:0]         mode_q, mode_d;
   logic               zero_q, zero_d, issued_q, issued_d;
   logic               done_q, done_d, err_q, err_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               mul_start, mul_busy, mul_done;
   logic [254:0]       mul_y, mul_res;

   mul_25519 u_mul (
      .clk(clk), .rst(rst), .start(mul_start), .x(result_q), .y(mul_y),
      .busy(mul_busy), .done(mul_done), .res(mul_res)
   );

`ifndef POW_CT_EN
   logic [IDX_W-1:0] top_idx;
   always_comb begin
      top_idx = '0;
      for (int i = 0; i < EXP_W; i++)
         if (exp_q[i]) top_idx = IDX_W'(i);
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         base_q   <= '0;
         result_q <= '0;
         res_q    <= '0;
         exp_q    <= '0;
         mode_q   <= '0;
         zero_q   <= 1'b0;
         issued_q <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         idx_q    <= '0;
      end else begin
         state_q  <= state_d;
         base_q   <= base_d;
         result_q <= result_d;
         res_q    <= res_d;
         exp_q    <= exp_d;
         mode_q   <= mode_d;
         zero_q   <= zero_d;
         issued_q <= issued_d;
         done_q   <= done_d;
         err_q    <= err_d;
         idx_q    <= idx_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      base_d   = base_q;
      result_d = result_q;
      res_d    = res_q;
      exp_d    = exp_q;
      mode_d   = mode_q;
      zero_d   = zero_q;
      issued_d = issued_q;
      err_d    = err_q;
      idx_d    = idx_q;
      done_d   = 1'b0;
      if (mul_start) issued_d = 1'b1;
      unique case (state_q)
         IDLE: if (start) begin
            base_d  = a;
            mode_d  = mode;
            zero_d  = (a == '0) || (a == P);
            case (mode)
               2'd0:    exp_d = E_INV_W;
               2'd1:    exp_d = E_SQRT_W;
               default: exp_d = e;
            endcase
            state_d = SCAN;
         end
         SCAN: begin
`ifdef POW_CT_EN
            result_d = ONE;
            idx_d    = IDX_W'(EXP_W - 1);
            state_d  = SQR;
`else
            if (exp_q == '0) begin
               result_d = ONE;
               state_d  = FINISH;
            end else begin
               result_d = base_q;
               idx_d    = top_idx;
               if (top_idx == '0) state_d = FINISH;
               else begin
                  idx_d   = top_idx - IDX_W'(1);
                  state_d = SQR;
               end
            end
`endif
         end
         SQR: if (mul_done) begin
            issued_d = 1'b0;
            result_d = mul_res;
`ifdef POW_CT_EN
            state_d  = MUL;
`else
            if (exp_q[idx_q]) state_d = MUL;
            else if (idx_q == '0) state_d = FINISH;
            else idx_d = idx_q - IDX_W'(1);
`endif
         end
         MUL: if (mul_done) begin
            issued_d = 1'b0;
`ifdef POW_CT_EN
            // Product is always computed; a zero bit simply drops it.
            if (exp_q[idx_q]) result_d = mul_res;
`else
            result_d = mul_res;
`endif
            if (idx_q == '0) state_d = FINISH;
            else begin
               idx_d   = idx_q - IDX_W'(1);
               state_d = SQR;
            end
         end
         FINISH: begin
            res_d   = result_q;
            err_d   = (mode_q == 2'd0) && zero_q;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy      = (state_q != IDLE);
      mul_start = ((state_q == SQR) || (state_q == MUL)) && !issued_q && !mul_busy && !mul_done;
      mul_y     = (state_q == MUL) ? base_q : result_q;
   end

   assign res  = res_q;
   assign done = done_q;
   assign err  = err_q;
endmodule

// File: tb/tb_pow_25519.sv
// Bench for pow_25519: vector table, hand-written corner sequences and randomized runs against a right-to-left modexp model.
module tb_pow_25519;
   localparam int EXP_W = 255;
   localparam int IDX_W = 8;
   localparam logic [254:0] P      = {255{1'b1}} - 255'd18;
   localparam logic [254:0] E_INV  = P - 255'd2;
   localparam logic [254:0] E_SQRT = (255'd1 << 252) - 255'd3;
`ifdef POW_CT_EN
   localparam bit CT = 1'b1;
`else
   localparam bit CT = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic [1:0]       mode = '0;
   logic [254:0]     a = '0;
   logic [EXP_W-1:0] e = '0;
   logic [254:0]     res;
   logic             done, err, busy;

   pow_25519 #(.EXP_W(EXP_W), .IDX_W(IDX_W)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a), .e(e),
      .res(res), .done(done), .err(err), .busy(busy)
   );

   always #5 clk = ~clk;

   int checks = 0, failures = 0;
   int cyc = 0, n_ops = 0, last_md = 0, last_done = 0;

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (dut.mul_start) n_ops = n_ops + 1;
      if (dut.mul_done)  last_md = cyc;
      if (done)          last_done = cyc;
   end

   typedef struct {
      logic [1:0]       m;
      logic [254:0]     a;
      logic [EXP_W-1:0] e;
      logic [254:0]     r;
      logic             er;
      int               ops;
      int               lat;
      int               gap;
   } vec_t;

   function automatic logic [254:0] mulmod(input logic [254:0] x, input logic [254:0] y);
      logic [509:0] xx, yy, pr;
      xx = {255'd0, x};
      yy = {255'd0, y};
      pr = (xx * yy) % {255'd0, P};
      return pr[254:0];
   endfunction

   function automatic logic [254:0] powmod(input logic [254:0] x, input logic [EXP_W-1:0] ev);
      logic [254:0] r, b;
      logic [509:0] xw;
      xw = {255'd0, x} % {255'd0, P};
      b = xw[254:0];
      r = 255'd1;
      for (int i = 0; i < EXP_W; i++) begin
         if (ev[i]) r = mulmod(r, b);
         b = mulmod(b, b);
      end
      return r;
   endfunction

   function automatic int ops_model(input logic [EXP_W-1:0] ev);
      int msb, pop;
      if (CT) return 2 * EXP_W;
      if (ev == '0) return 0;
      msb = 0;
      pop = 0;
      for (int i = 0; i < EXP_W; i++)
         if (ev[i]) begin
            msb = i;
            pop++;
         end
      return msb + pop - 1;
   endfunction

   task automatic chk(input string name, input logic [254:0] got, input logic [254:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", name, got, exp);
      end
   endtask

   task automatic launch(input logic [1:0] m, input logic [254:0] av, input logic [EXP_W-1:0] ev);
      @(negedge clk);
      mode = m; a = av; e = ev; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!done && n < 20000) begin
         @(negedge clk);
         n++;
      end
      if (!done) begin
         checks++;
         failures++;
         $display("FAIL timeout waiting for done after %0d cycles", n);
      end
   endtask

   task automatic run_vec(input string name, input vec_t v);
      int n0, n;
      n0 = n_ops;
      launch(v.m, v.a, v.e);
      wait_done(n);
      chk({name, "_res"}, res, v.r);
      chk({name, "_err"}, 255'(err), 255'(v.er));
      @(posedge clk);
      #1;
      chk({name, "_done_pulse"}, 255'(done), 255'd0);
      chk({name, "_ops"}, 255'(n_ops - n0), 255'(v.ops));
      if (v.lat >= 0) chk({name, "_latency"}, 255'(n + 1), 255'(v.lat));
      if (v.gap >= 0) chk({name, "_done_gap"}, 255'(last_done - last_md), 255'(v.gap));
   endtask

   initial begin
      vec_t tbl[6];
      vec_t rv;
      logic [254:0] last_exp, ra, exp_r;
      logic [EXP_W-1:0] re;
      int n, n0;

      tbl[0] = '{2'd0, 255'd2, '0, (255'd1 << 254) - 255'd9, 1'b0, CT ? 510 : 506, -1, 2};
      tbl[1] = '{2'd0, 255'd0, '0, 255'd0, 1'b1, CT ? 510 : 506, -1, 2};
      tbl[2] = '{2'd0, P, '0, 255'd0, 1'b1, CT ? 510 : 506, -1, 2};
      tbl[3] = '{2'd2, 255'd5, 255'd3, 255'd125, 1'b0, CT ? 510 : 2, -1, 2};
      tbl[4] = '{2'd2, 255'd7, 255'd0, 255'd1, 1'b0, CT ? 510 : 0, CT ? -1 : 3, CT ? 2 : -1};
      tbl[5] = '{2'd3, 255'd7, 255'd1, 255'd7, 1'b0, CT ? 510 : 0, CT ? -1 : 3, CT ? 2 : -1};

      #1 rst = 1'b0;
      #12;
      chk("reset_res", res, 255'd0);
      chk("reset_done", 255'(done), 255'd0);
      chk("reset_err", 255'(err), 255'd0);
      chk("reset_busy", 255'(busy), 255'd0);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 6; i++) run_vec($sformatf("vec%0d", i), tbl[i]);
      last_exp = tbl[5].r;

      // Long sqrt-exponent run with start pulses while busy
      n0 = n_ops;
      launch(2'd1, 255'd4, '0);
      repeat (200) @(negedge clk);
      chk("busy_mid", 255'(busy), 255'd1);
      chk("res_held_mid", res, last_exp);
      mode = 2'd2; a = 255'd9; e = 255'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (50) @(negedge clk);
      chk("res_held_after_poke", res, last_exp);
      wait_done(n);
      chk("sqrt_res", res, powmod(255'd4, E_SQRT[EXP_W-1:0]));
      chk("sqrt_err", 255'(err), 255'd0);
      @(posedge clk);
      #1;
      chk("sqrt_ops", 255'(n_ops - n0), 255'(ops_model(E_SQRT[EXP_W-1:0])));

      // Back-to-back: next start raised in the cycle done is high
      launch(2'd2, 255'd5, 255'd3);
      wait_done(n);
      mode = 2'd2; a = 255'd9; e = 255'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("b2b_busy", 255'(busy), 255'd1);
      wait_done(n);
      chk("b2b_res", res, 255'd81);

      // Asynchronous reset in the middle of an inversion
      launch(2'd0, 255'd2, '0);
      repeat (2000) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("abort_res", res, 255'd0);
      chk("abort_done", 255'(done), 255'd0);
      chk("abort_err", 255'(err), 255'd0);
      chk("abort_busy", 255'(busy), 255'd0);
      @(negedge clk);
      rst = 1'b1;
      run_vec("after_reset", tbl[0]);

      // Randomized runs against the model
      for (int k = 0; k < 4; k++) begin
         ra = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         if (k == 0) begin
            rv.m = 2'd0;
            re = E_INV[EXP_W-1:0];
         end else begin
            rv.m = 2'd2 + 2'($urandom_range(0, 1));
            re = EXP_W'($urandom_range(0, 32'h00FF_FFFF));
         end
         exp_r = powmod(ra, re);
         rv.a = ra;
         rv.e = re;
         rv.r = exp_r;
         rv.er = (rv.m == 2'd0) && (powmod(ra, 255'd1) == 255'd0);
         rv.ops = ops_model(re);
         rv.lat = -1;
         rv.gap = -1;
         run_vec($sformatf("rand%0d", k), rv);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/pow_25519.md
Name: pow_25519

Overview:
- Parametrised modular exponentiation engine over GF(p), p = 2^255-19. Computes res = a^e mod p.
- Exponent is selected per operation: inverse (e = p-2), sqrt-candidate (e = (p-5)/8 = 2^252-3), or a user-supplied exponent.
- Shares the single mul_25519 instance handshake (start/done/busy). Serves point decompression and affine conversion in the ED25519 datapath.

Parameters:
- EXP_W, 255, width of the user exponent port and of the exponent scan register (8..255).
- IDX_W, 8, width of the bit-index counter; must satisfy 2^IDX_W > EXP_W.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- mode  in  2  0=inverse, 1=sqrt exponent (p-5)/8, 2/3=user exponent
- a  in  255  base, any value < 2^255; multiplier reduces it
- e  in  EXP_W  user exponent; used only when mode is 2 or 3
- res  out  255  result; held until the next done
- done  out  1  single-cycle completion pulse
- err  out  1  valid with done; high when mode=0 and a is 0 mod p (a==0 or a==p)
- busy  out  1  high whenever state != IDLE (combinational from state)

Behaviour:
- Reset: state=IDLE, res=0, done=0, err=0, mul_start=0, internal regs=0. Reset mid-operation aborts immediately. The multiplier is reset by the same rst.
- States: IDLE, SCAN, SQR, MUL, FINISH.
- IDLE: done<=0. On start, latch a, mode, exponent (EXP_W-bit, zero-extended constants), and zero flag (a==0 || a==p); go to SCAN. A start outside IDLE is ignored.
- SCAN: find the highest set bit k of the exponent. Combinational priority encode is permitted; SCAN lasts exactly 1 cycle.
  - Exponent zero: result=1, go to FINISH.
  - Otherwise: result=base, idx=k. If k==0 go to FINISH, else idx=k-1 and go to SQR.
- SQR: issue result*result; on mul_done, latch the product. If exp[idx] go to MUL; else if idx==0 go to FINISH, else decrement idx and stay in SQR.
- MUL: issue result*base; on mul_done, latch the product. If idx==0 go to FINISH, else decrement idx and go to SQR.
- Multiplier handshake: assert mul_start for exactly one cycle per operation. Issue only when !mul_busy && !mul_done. Never issue a second start before the matching mul_done.
- FINISH (1 cycle):
  - res<=result, err<=(mode==0 && zero flag), done<=1, go to IDLE.
  - done therefore pulses exactly 2 cycles after the final mul_done (or 2 cycles after SCAN when there are no ops).
  - When err=1, res=0; natural since 0^e=0.
- Operation count (non-CT): (k squarings) + (popcount(e)-1 multiplies).
  - mode 0: 254 SQR + 252 MUL = 506 ops.
  - mode 1: 251 SQR + 250 MUL = 501 ops.
- Arithmetic: all products come from mul_25519 and are fully reduced mod p. a=0 with e>0 gives 0. 0^0 = 1.
- Back-to-back: start may be asserted in the cycle done is high. It is accepted on the following IDLE cycle, and done is low that cycle.

Optional Feature:
- Macro POW_CT_EN.
- Defined (constant-time):
  - SCAN does not skip leading zeros: result=1, idx=EXP_W-1.
  - Every bit performs SQR then MUL. The MUL uses base when the bit is 1, otherwise the product is discarded with result unchanged.
  - Ops = 2*EXP_W regardless of exponent or a; 510 for EXP_W=255 in every mode.
  - err still reported.
- Not defined: variable-time scan as above.

Test Plan:
- mode=0, a=2 -> res = 2^254-9 (0x3FFF...FFF7), err=0; 506 mul_start pulses (510 with POW_CT_EN).
- mode=0, a=0 and a=p -> res=0, err=1, done single-cycle pulse.
- mode=2, e=3, a=5 -> res=125; 2 ops (1 SQR, 1 MUL); done 2 cycles after the second mul_done.
- mode=2, e=0, a=7 -> res=1, zero mul_start pulses, done 3 cycles after start accepted; mode=2, e=1, a=7 -> res=7, zero ops.
- mode=1, a=4 -> res = 4^((p-5)/8) matches the golden model; 501 ops. Start pulses while busy are ignored; res is unchanged until done.
- Assert rst low midway through a mode=0 run -> all outputs return to reset values asynchronously. A fresh mode=0, a=2 run after release -> correct result.
